// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared widths, mode encoding and bus-source priority for the SAP datapath
package sap_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic [1:0] {
    MODE_LOAD = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_HALT = 2'b10
  } mode_t;

  typedef enum logic [2:0] {
    SRC_NONE = 3'd0,
    SRC_CO   = 3'd1,
    SRC_IO   = 3'd2,
    SRC_RO   = 3'd3,
    SRC_AO   = 3'd4,
    SRC_EO   = 3'd5
  } bus_src_t;

  // Highest-priority enabled driver wins: eo > ao > ro > io > co.
  function automatic bus_src_t bus_sel(input logic eo, input logic ao, input logic ro,
                                       input logic io, input logic co);
    if (eo)      return SRC_EO;
    else if (ao) return SRC_AO;
    else if (ro) return SRC_RO;
    else if (io) return SRC_IO;
    else if (co) return SRC_CO;
    else         return SRC_NONE;
  endfunction

endpackage

// File: rtl/sap_ram16.sv
// rtl/sap_ram16.sv - synchronous-write, asynchronous-read program/data RAM
module sap_ram16 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately not reset so a program survives rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_datapath.sv
// rtl/sap_datapath.sv - SAP datapath responder; SAP_BUS_CONTENTION_CHK_EN enables the sticky bus_err check
module sap_datapath
  import sap_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hlt,
  input  logic              ri,
  input  logic              su,
  input  logic              oi,
  input  logic              ce,
  input  logic              mi_n,
  input  logic              ro_n,
  input  logic              io_n,
  input  logic              ii_n,
  input  logic              ai_n,
  input  logic              ao_n,
  input  logic              eo_n,
  input  logic              bi_n,
  input  logic              co_n,
  input  logic              j_n,
  input  logic              fi_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        ir_op,
  output logic              cf,
  output logic              zf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [1:0]        mode,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              bus_err
);

  mode_t             mode_q;
  logic              run;
  logic [ADDR_W-1:0] pc_q, mar_q;
  logic [DATA_W-1:0] ir_q, a_q, b_q, out_q, ram_rdata, bus;
  logic              cf_q, zf_q, ov_q;
  logic [DATA_W:0]   sum;
  bus_src_t          src;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign run = (mode_q == MODE_RUN);

  // Subtraction as two's-complement add; carry out = 1 means no borrow.
  assign sum = {1'b0, a_q} + (su ? ({1'b0, ~b_q} + {{DATA_W{1'b0}}, 1'b1}) : {1'b0, b_q});

  assign src = bus_sel(~eo_n, ~ao_n, ~ro_n, ~io_n, ~co_n);

  always_comb begin
    bus = '0;
    case (src)
      SRC_EO:  bus = sum[DATA_W-1:0];
      SRC_AO:  bus = a_q;
      SRC_RO:  bus = ram_rdata;
      SRC_IO:  bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
      SRC_CO:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      default: bus = '0;
    endcase
  end

  assign ram_we    = run ? ri : prog_we;
  assign ram_waddr = run ? mar_q : prog_addr;
  assign ram_wdata = run ? bus : prog_data;

  sap_ram16 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (mar_q),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_LOAD;
      pc_q   <= '0;
      mar_q  <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      out_q  <= '0;
      cf_q   <= 1'b0;
      zf_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      ov_q <= run & oi;
      case (mode_q)
        MODE_LOAD: begin
          if (start) mode_q <= MODE_RUN;
        end
        MODE_RUN: begin
          if (!mi_n) mar_q <= bus[ADDR_W-1:0];
          if (!ii_n) ir_q  <= bus;
          if (!ai_n) a_q   <= bus;
          if (!bi_n) b_q   <= bus;
          if (oi)    out_q <= bus;
          if (!fi_n) begin
            cf_q <= sum[DATA_W];
            zf_q <= (sum[DATA_W-1:0] == '0);
          end
          if (!j_n)    pc_q <= bus[ADDR_W-1:0];
          else if (ce) pc_q <= pc_q + 1'b1;
          if (hlt) mode_q <= MODE_HALT;
        end
        MODE_HALT: begin
          if (start) begin
            mode_q <= MODE_RUN;
            pc_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
            out_q  <= '0;
          end
        end
        default: mode_q <= MODE_LOAD;
      endcase
    end
  end

`ifdef SAP_BUS_CONTENTION_CHK_EN
  logic bus_err_q;
  logic multi_drv;

  assign multi_drv = ($countones({~eo_n, ~ao_n, ~ro_n, ~io_n, ~co_n}) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err_q <= 1'b0;
    end else if (run && multi_drv) begin
      bus_err_q <= 1'b1;
      assert (1'b0) else $error("sap_datapath: multiple bus drivers enabled");
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign ir_op     = ir_q[DATA_W-1:DATA_W-4];
  assign cf        = cf_q;
  assign zf        = zf_q;
  assign out_data  = out_q;
  assign out_valid = ov_q;
  assign halted    = (mode_q == MODE_HALT);
  assign mode      = mode_q;
  assign bus_dbg   = bus;

endmodule

// File: tb/tb_sap_datapath.sv
// tb/tb_sap_datapath.sv - directed table-driven bench for sap_datapath
module tb_sap_datapath;

  localparam logic [15:0] HLT = 16'h8000, RI = 16'h4000, SU = 16'h2000, OI = 16'h1000;
  localparam logic [15:0] CE  = 16'h0800, MI = 16'h0400, RO = 16'h0200, IO = 16'h0100;
  localparam logic [15:0] II  = 16'h0080, AI = 16'h0040, AO = 16'h0020, EO = 16'h0010;
  localparam logic [15:0] BI  = 16'h0008, CO = 16'h0004, JP = 16'h0002, FI = 16'h0001;

  logic       clk, rst_n;
  logic       hlt, ri, su, oi, ce;
  logic       mi_n, ro_n, io_n, ii_n, ai_n, ao_n, eo_n, bi_n, co_n, j_n, fi_n;
  logic       start, prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] ir_op;
  logic       cf, zf, out_valid, halted, bus_err;
  logic [7:0] out_data, bus_dbg;
  logic [1:0] mode;

  int n_pass, n_total;

  typedef struct {
    logic [15:0] ctrl;
    logic [7:0]  bus;
    logic [3:0]  op;
    logic        cf;
    logic        zf;
    logic [7:0]  out;
    logic        ov;
  } vec_t;

  vec_t vq[$];

  sap_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .hlt(hlt), .ri(ri), .su(su), .oi(oi), .ce(ce),
    .mi_n(mi_n), .ro_n(ro_n), .io_n(io_n), .ii_n(ii_n), .ai_n(ai_n), .ao_n(ao_n),
    .eo_n(eo_n), .bi_n(bi_n), .co_n(co_n), .j_n(j_n), .fi_n(fi_n),
    .start(start), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .ir_op(ir_op), .cf(cf), .zf(zf), .out_data(out_data), .out_valid(out_valid),
    .halted(halted), .mode(mode), .bus_dbg(bus_dbg), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_ctrl(input logic [15:0] c);
    {hlt, ri, su, oi, ce} = c[15:11];
    mi_n = ~c[10]; ro_n = ~c[9]; io_n = ~c[8]; ii_n = ~c[7]; ai_n = ~c[6];
    ao_n = ~c[5];  eo_n = ~c[4]; bi_n = ~c[3]; co_n = ~c[2]; j_n = ~c[1]; fi_n = ~c[0];
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [15:0] c, input string nm, input logic [7:0] exp_bus);
    set_ctrl(c);
    #1 chk(nm, bus_dbg, exp_bus);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic [15:0] c, input logic [7:0] b, input logic [3:0] op,
                     input logic f_c, input logic f_z, input logic [7:0] o, input logic v);
    vec_t v_;
    v_.ctrl = c; v_.bus = b; v_.op = op; v_.cf = f_c; v_.zf = f_z; v_.out = o; v_.ov = v;
    vq.push_back(v_);
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(posedge clk);
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    set_ctrl(16'h0000);

    // ctrl, bus during step, then ir_op/cf/zf/out_data/out_valid after the edge
    add(CO|MI,    8'h00, 4'h0, 0, 0, 8'h00, 0);
    add(RO|II|CE, 8'h1E, 4'h1, 0, 0, 8'h00, 0);
    add(IO|MI,    8'h0E, 4'h1, 0, 0, 8'h00, 0);
    add(RO|AI,    8'h1C, 4'h1, 0, 0, 8'h00, 0);
    add(CO|MI,    8'h01, 4'h1, 0, 0, 8'h00, 0);
    add(RO|II|CE, 8'h2F, 4'h2, 0, 0, 8'h00, 0);
    add(IO|MI,    8'h0F, 4'h2, 0, 0, 8'h00, 0);
    add(RO|BI,    8'h0E, 4'h2, 0, 0, 8'h00, 0);
    add(EO|AI|FI, 8'h2A, 4'h2, 0, 0, 8'h00, 0);
    add(AO|OI,    8'h2A, 4'h2, 0, 0, 8'h2A, 1);
    add(CO|MI,    8'h02, 4'h2, 0, 0, 8'h2A, 0);
    add(RO|AI,    8'h05, 4'h2, 0, 0, 8'h2A, 0);
    add(RO|BI,    8'h05, 4'h2, 0, 0, 8'h2A, 0);
    add(SU|EO|FI, 8'h00, 4'h2, 1, 1, 8'h2A, 0);
    add(CE,       8'h00, 4'h2, 1, 1, 8'h2A, 0);
    add(CO|MI,    8'h03, 4'h2, 1, 1, 8'h2A, 0);
    add(RO|AI,    8'h03, 4'h2, 1, 1, 8'h2A, 0);
    add(SU|EO|FI, 8'hFE, 4'h2, 0, 0, 8'h2A, 0);
    add(AO|AI,    8'h03, 4'h2, 0, 0, 8'h2A, 0);
    add(AO,       8'h03, 4'h2, 0, 0, 8'h2A, 0);
    add(IO|JP,    8'h0F, 4'h2, 0, 0, 8'h2A, 0);
    add(CE,       8'h00, 4'h2, 0, 0, 8'h2A, 0);
    add(CO,       8'h00, 4'h2, 0, 0, 8'h2A, 0);
    add(RO|CE|JP, 8'h03, 4'h2, 0, 0, 8'h2A, 0);
    add(CO,       8'h03, 4'h2, 0, 0, 8'h2A, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst mode", mode, 2'b00);
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 8'h00);
    chk("rst flags", {cf, zf}, 2'b00);
    chk("rst ir_op", ir_op, 4'h0);
    chk("rst bus_err", bus_err, 1'b0);
    set_ctrl(CO); #1 chk("rst pc", bus_dbg, 8'h00);
    set_ctrl(AO); #1 chk("rst a", bus_dbg, 8'h00);
    set_ctrl(16'h0000);
    @(negedge clk);

    prog(4'd0, 8'h1E); prog(4'd1, 8'h2F); prog(4'd2, 8'h05);
    prog(4'd3, 8'h03); prog(4'd14, 8'h1C); prog(4'd15, 8'h0E);
    chk("load mode", mode, 2'b00);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start mode", mode, 2'b01);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].ctrl, $sformatf("vec%0d bus", i), vq[i].bus);
      chk($sformatf("vec%0d ir_op", i), ir_op, vq[i].op);
      chk($sformatf("vec%0d cf", i), cf, vq[i].cf);
      chk($sformatf("vec%0d zf", i), zf, vq[i].zf);
      chk($sformatf("vec%0d out_data", i), out_data, vq[i].out);
      chk($sformatf("vec%0d out_valid", i), out_valid, vq[i].ov);
    end

    // hlt with ce: ce still applies (PC 3 -> 4), then everything freezes
    step(HLT|CE, "hlt bus", 8'h00);
    chk("hlt mode", mode, 2'b10);
    chk("hlt halted", halted, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(CO|CE|AI|OI, $sformatf("halt%0d pc", i), 8'h04);
      chk($sformatf("halt%0d mode", i), mode, 2'b10);
    end
    chk("halt out_valid", out_valid, 1'b0);
    start = 1'b1;
    step(CO, "restart pre pc", 8'h04);
    start = 1'b0;
    chk("restart mode", mode, 2'b01);
    chk("restart halted", halted, 1'b0);
    chk("restart out_data", out_data, 8'h00);
    step(CO, "restart pc", 8'h00);
    step(AO, "restart a", 8'h00);

    // build up state, then assert reset while clk is high
    step(RO|AI, "pre-rst a", 8'h03);
    step(AO|OI|SU|FI, "pre-rst oi", 8'h03);
    chk("pre-rst cf", cf, 1'b1);
    chk("pre-rst out", out_data, 8'h03);
    set_ctrl(AO);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst mode", mode, 2'b00);
    chk("async rst a", bus_dbg, 8'h00);
    chk("async rst cf", cf, 1'b0);
    chk("async rst out", out_data, 8'h00);
    chk("async rst ir_op", ir_op, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ctrl(RO); #1 chk("ram retained", bus_dbg, 8'h1E);
    @(negedge clk);

    start = 1'b1;
    step(16'h0000, "cont start", 8'h00);
    start = 1'b0;
    step(RO|AI, "cont a", 8'h1E);
    step(RO|BI, "cont b", 8'h1E);
    step(AO|EO, "cont bus", 8'h3C);
`ifdef SAP_BUS_CONTENTION_CHK_EN
    chk("bus_err", bus_err, 1'b1);
`else
    chk("bus_err", bus_err, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
Name: sap_datapath

Overview:
- Datapath responder for the microcoded 8-bit control unit. Consumes one control word per clock, executes the bus transfers, ALU operations and memory accesses it names, and returns the opcode nibble and the CF/ZF flags to the controller.
- Holds PC, MAR, IR, A, B, the flags register, the output register and a 16-byte RAM.
- A small mode FSM (LOAD/RUN/HALT) gates program loading and execution.

Parameters:
- DATA_W, 8, bus/register width; opcode is IR[DATA_W-1:DATA_W-4].
- ADDR_W, 4, PC/MAR/RAM address width; RAM depth 2^ADDR_W; must satisfy ADDR_W <= DATA_W-4.

Ports:
- clk  in  1  system clock; all state updates on rising edge. The controller changes the control word on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- hlt, ri, su, oi, ce  in  1 each  active-high control bits.
- mi_n, ro_n, io_n, ii_n, ai_n, ao_n, eo_n, bi_n, co_n, j_n, fi_n  in  1 each  active-low control bits.
- start  in  1  pulse; enters RUN from LOAD or HALT.
- prog_we  in  1  RAM program-write strobe.
- prog_addr  in  ADDR_W  program-write address.
- prog_data  in  DATA_W  program-write data.
- ir_op  out  4  IR[DATA_W-1:DATA_W-4], to controller.
- cf, zf  out  1 each  latched flags, to controller.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-cycle pulse when out_data is loaded.
- halted  out  1  high in HALT.
- mode  out  2  00 LOAD, 01 RUN, 10 HALT.
- bus_dbg  out  DATA_W  current bus value.
- bus_err  out  1  sticky contention flag (see Optional Feature).

Behaviour:
- Reset: PC, MAR, IR, A, B, cf, zf, out_data = 0; out_valid = 0; bus_err = 0; mode = LOAD. RAM contents are not reset.
- FSM:
  - LOAD: prog_we writes RAM[prog_addr] = prog_data; control word ignored; start moves to RUN.
  - RUN: control word honoured each rising edge; prog_we ignored; hlt = 1 moves to HALT. Other control bits in the hlt cycle are still applied.
  - HALT: all registers frozen; prog_we allowed; start moves to RUN and clears PC, A, B, flags and out_data the same edge.
  - start in RUN is ignored.
- Bus (combinational): drivers are co (PC, zero-extended), ro (RAM[MAR]), io (IR low ADDR_W bits, zero-extended), ao (A), eo (ALU sum). Priority when several are enabled: eo > ao > ro > io > co. No driver gives bus = 0.
- ALU (combinational): sum = A + (su ? ~B + 1 : B), computed DATA_W+1 bits wide.
  - carry = bit DATA_W. For subtraction, carry = 1 means no borrow; 5 - 3 gives carry 1, 3 - 5 gives 0xFE with carry 0.
  - zero = (sum[DATA_W-1:0] == 0).
- Rising-edge loads in RUN (all loads in one cycle see the pre-edge bus):
  - mi: MAR <= bus[ADDR_W-1:0].
  - ri: RAM[MAR] <= bus.
  - ii: IR <= bus.
  - ai: A <= bus.
  - bi: B <= bus.
  - fi: cf, zf <= ALU carry, zero.
  - oi: out_data <= bus and out_valid = 1 for the next cycle.
  - ce: PC <= PC + 1, wrapping 2^ADDR_W-1 to 0.
  - j: PC <= bus[ADDR_W-1:0]; overrides ce in the same cycle.
- Same register as source and destination (e.g. ao with ai) leaves the value unchanged.
- ri and ro in the same cycle: the read returns the old value.
- Latency: every transfer completes in 1 cycle; flags are visible to the controller the cycle after fi.

Optional Feature:
- Macro: SAP_BUS_CONTENTION_CHK_EN.
- Defined: bus_err is set sticky in RUN whenever more than one bus driver is enabled; cleared only by reset. A simulation $error is issued at the offending edge.
- Undefined: bus_err tied to 0; the priority mux alone resolves contention.

Decomposition:
- Package sap_pkg: mode enum (MODE_LOAD = 2'b00, MODE_RUN = 2'b01, MODE_HALT = 2'b10), bus-source priority encoding, default widths.
- Sub-module sap_ram16: synchronous-write, asynchronous-read RAM with a single muxed write port (program port or ri).

Test Plan:
- Load RAM {0:0x1E, 1:0x2F, 14:0x1C, 15:0x0E}, start, drive LDA 14 / ADD 15 microsteps -> A = 0x2A, cf = 0, zf = 0.
- A = 0x05, B = 0x05, su = 1, fi -> zf = 1, cf = 1; then A = 0x03, B = 0x05 -> sum 0xFE, cf = 0.
- PC = 0xF with ce -> PC = 0x0; ce and j together with bus = 0x3 -> PC = 0x3.
- oi with A = 0x2A on bus -> out_data = 0x2A, out_valid high exactly 1 cycle; hlt -> mode = HALT, PC frozen over 10 clocks; start -> PC = 0, mode = RUN.
- rst_n low mid-RUN -> all registers 0, mode = LOAD immediately (asynchronous); RAM contents retained.
- ao_n and eo_n both low -> bus = ALU sum; bus_err = 1 only when SAP_BUS_CONTENTION_CHK_EN is defined, else 0.
